// File: rtl/dpp_pkg.sv
// Shared types and helpers for the dining-philosophers table arbiter.
package dpp_pkg;

  typedef enum logic [1:0] {
    ST_THINKING = 2'd0,
    ST_HUNGRY   = 2'd1,
    ST_EATING   = 2'd2
  } philo_state_e;

  // Reduce an index modulo the table size.
  function automatic int wrap_idx(input int idx, input int n);
    return idx % n;
  endfunction

  // Philosopher p uses fork p on the left.
  function automatic int left_fork(input int p, input int n);
    return wrap_idx(p, n);
  endfunction

  // Philosopher p uses fork p+1 (wrapping) on the right.
  function automatic int right_fork(input int p, input int n);
    return wrap_idx(p + 1, n);
  endfunction

  // The philosopher that uses fork f as its right fork.
  function automatic int right_user(input int f, input int n);
    return wrap_idx(f + n - 1, n);
  endfunction

  // Saturation value of a wait-age counter of width tw.
  function automatic int age_max(input int tw);
    return (1 << tw) - 1;
  endfunction

endpackage

// File: rtl/philo_pick.sv
// Grant selector: oldest eligible philosopher wins, ties broken round-robin
// starting at rr_ptr and scanning upward.
module philo_pick
  import dpp_pkg::*;
#(
  parameter int N  = 4,
  parameter int TW = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]    eligible,
  input  logic [N*TW-1:0] ages,
  input  logic [IW-1:0]   rr_ptr,
  output logic            valid,
  output logic [IW-1:0]   index
);

  // Only a strictly greater age displaces the current pick, so equal ages
  // keep the candidate met first in the scan from rr_ptr.
  always_comb begin
    logic [TW-1:0] best_age;
    int            p;
    valid    = 1'b0;
    index    = '0;
    best_age = '0;
    p        = 0;
    for (int k = 0; k < N; k++) begin
      p = wrap_idx(int'(rr_ptr) + k, N);
      if (eligible[p] && (!valid || (ages[p*TW +: TW] > best_age))) begin
        valid    = 1'b1;
        index    = IW'(p);
        best_age = ages[p*TW +: TW];
      end
    end
  end

endmodule

// File: rtl/table_arbiter.sv
// Dining-philosophers fork arbiter: per-philosopher THINKING/HUNGRY/EATING
// state, one grant per cycle, age-based fairness with round-robin ties.
module table_arbiter
  import dpp_pkg::*;
#(
  parameter int N_PHILO    = 4,
  parameter int TIMER_SIZE = 4
) (
  input  logic               clk,
  input  logic               srst,
  input  logic [N_PHILO-1:0] hungry,
  input  logic [N_PHILO-1:0] done,
  output logic [N_PHILO-1:0] may_eat,
  output logic [N_PHILO-1:0] eating,
  output logic [N_PHILO-1:0] fork_busy,
  output logic [N_PHILO-1:0] starving,
  output logic               proto_err
);

  localparam int IW = (N_PHILO > 1) ? $clog2(N_PHILO) : 1;
  localparam logic [TIMER_SIZE-1:0] AGE_SAT = TIMER_SIZE'(age_max(TIMER_SIZE));

  philo_state_e          state_reg [N_PHILO];
  philo_state_e          state_next [N_PHILO];
  logic [TIMER_SIZE-1:0] age_reg [N_PHILO];
  logic [TIMER_SIZE-1:0] age_next [N_PHILO];
  logic [IW-1:0]         rr_ptr_reg, rr_ptr_next;

  logic [N_PHILO-1:0]    may_eat_reg, may_eat_next;
  logic [N_PHILO-1:0]    eating_reg, eating_next;
  logic [N_PHILO-1:0]    fork_busy_reg, fork_busy_next;
  logic [N_PHILO-1:0]    starving_reg, starving_next;
  logic                  proto_err_reg, proto_err_next;

  logic [N_PHILO-1:0]            eligible;
  logic [N_PHILO*TIMER_SIZE-1:0] ages_flat;
  logic                          pick_valid;
  logic [IW-1:0]                 pick_idx;

  // Eligibility uses the registered fork state, so forks freed at one edge
  // become grantable at the following edge.
  genvar gi;
  generate
    for (gi = 0; gi < N_PHILO; gi++) begin : g_philo
      localparam int LF = left_fork(gi, N_PHILO);
      localparam int RF = right_fork(gi, N_PHILO);
      localparam int RU = right_user(gi, N_PHILO);
      assign eligible[gi] = (state_reg[gi] == ST_HUNGRY) &&
                            !fork_busy_reg[LF] && !fork_busy_reg[RF];
      assign ages_flat[gi*TIMER_SIZE +: TIMER_SIZE] = age_reg[gi];
      // Fork gi is held whenever either of its two users is eating.
      assign fork_busy_next[gi] = eating_next[gi] | eating_next[RU];
    end
  endgenerate

  philo_pick #(
    .N  (N_PHILO),
    .TW (TIMER_SIZE),
    .IW (IW)
  ) u_pick (
    .eligible (eligible),
    .ages     (ages_flat),
    .rr_ptr   (rr_ptr_reg),
    .valid    (pick_valid),
    .index    (pick_idx)
  );

  // State register: philosopher states, ages, round-robin pointer, outputs.
  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < N_PHILO; i++) begin
        state_reg[i] <= ST_THINKING;
        age_reg[i]   <= '0;
      end
      rr_ptr_reg    <= '0;
      may_eat_reg   <= '0;
      eating_reg    <= '0;
      fork_busy_reg <= '0;
      starving_reg  <= '0;
      proto_err_reg <= 1'b0;
    end else begin
      for (int i = 0; i < N_PHILO; i++) begin
        state_reg[i] <= state_next[i];
        age_reg[i]   <= age_next[i];
      end
      rr_ptr_reg    <= rr_ptr_next;
      may_eat_reg   <= may_eat_next;
      eating_reg    <= eating_next;
      fork_busy_reg <= fork_busy_next;
      starving_reg  <= starving_next;
      proto_err_reg <= proto_err_next;
    end
  end

  // Next-state logic: request/finish handling, grant, age counting.
  always_comb begin
    logic err;
    err = 1'b0;
    for (int i = 0; i < N_PHILO; i++) begin
      state_next[i] = state_reg[i];
      age_next[i]   = age_reg[i];
      case (state_reg[i])
        ST_THINKING: begin
          if (hungry[i]) state_next[i] = ST_HUNGRY;
          if (done[i])   err = 1'b1;
        end
        ST_HUNGRY: begin
          if (hungry[i] || done[i]) err = 1'b1;
          if (pick_valid && (int'(pick_idx) == i)) begin
            state_next[i] = ST_EATING;
            age_next[i]   = '0;
          end else if (age_reg[i] != AGE_SAT) begin
            age_next[i] = age_reg[i] + TIMER_SIZE'(1);
          end
        end
        ST_EATING: begin
          if (done[i]) begin
            // A simultaneous request re-queues the philosopher straight away.
            state_next[i] = hungry[i] ? ST_HUNGRY : ST_THINKING;
            age_next[i]   = '0;
          end else if (hungry[i]) begin
            err = 1'b1;
          end
        end
        default: begin
          state_next[i] = ST_THINKING;
          age_next[i]   = '0;
        end
      endcase
    end
    proto_err_next = proto_err_reg | err;
    rr_ptr_next    = rr_ptr_reg;
    if (pick_valid) begin
      rr_ptr_next = (pick_idx == IW'(N_PHILO - 1)) ? '0 : pick_idx + IW'(1);
    end
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    may_eat_next = '0;
    if (pick_valid) may_eat_next[pick_idx] = 1'b1;
    for (int i = 0; i < N_PHILO; i++) begin
      eating_next[i]   = (state_next[i] == ST_EATING);
      starving_next[i] = (age_next[i] == AGE_SAT);
    end
  end

  assign may_eat   = may_eat_reg;
  assign eating    = eating_reg;
  assign fork_busy = fork_busy_reg;
  assign starving  = starving_reg;
  assign proto_err = proto_err_reg;

endmodule

// File: tb/tb_table_arbiter.sv
// Self-checking bench for table_arbiter (N_PHILO=4, TIMER_SIZE=2).
module tb_table_arbiter;

  logic       clk = 1'b0;
  logic       srst = 1'b1;
  logic [3:0] hungry = '0;
  logic [3:0] done = '0;
  logic [3:0] may_eat, eating, fork_busy, starving;
  logic       proto_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       rst;
    logic [3:0] h;
    logic [3:0] d;
    logic [3:0] may;
    logic [3:0] eat;
    logic [3:0] fb;
    logic [3:0] st;
    logic       err;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   row = 0;

  table_arbiter #(
    .N_PHILO    (4),
    .TIMER_SIZE (2)
  ) dut (
    .clk       (clk),
    .srst      (srst),
    .hungry    (hungry),
    .done      (done),
    .may_eat   (may_eat),
    .eating    (eating),
    .fork_busy (fork_busy),
    .starving  (starving),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  task automatic add(input logic rst, input logic [3:0] h, input logic [3:0] d,
                     input logic [3:0] may, input logic [3:0] eat,
                     input logic [3:0] fb, input logic [3:0] st, input logic err);
    vec_t v;
    v.rst = rst; v.h = h; v.d = d;
    v.may = may; v.eat = eat; v.fb = fb; v.st = st; v.err = err;
    vecs.push_back(v);
  endtask

  task automatic chk4(input string name, input logic [3:0] got, input logic [3:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL row %0d %s: got %b want %b", row, name, got, want);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic step(input vec_t v);
    vec_t e;
    @(negedge clk);
    srst   = v.rst;
    hungry = v.h;
    done   = v.d;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    hungry = '0;
    done   = '0;
    e = exp_q.pop_front();
    $display("row %0d: srst=%b hungry=%b done=%b -> may_eat=%b eating=%b fork_busy=%b starving=%b proto_err=%b",
             row, v.rst, v.h, v.d, may_eat, eating, fork_busy, starving, proto_err);
    chk4("may_eat", may_eat, e.may);
    chk4("eating", eating, e.eat);
    chk4("fork_busy", fork_busy, e.fb);
    chk4("starving", starving, e.st);
    chk4("proto_err", {3'b000, proto_err}, {3'b000, e.err});
    row++;
  endtask

  initial begin
    int   lat;
    vec_t v;
    //   rst  hungry   done     may_eat  eating   fork_busy starving err
    add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0); // reset
    add(1, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0); // reset beats inputs
    add(0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0); // p0 hungry
    add(0, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0011, 4'b0000, 0); // p0 granted
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0011, 4'b0000, 0); // one-cycle pulse
    add(0, 4'b0010, 4'b0000, 4'b0000, 4'b0001, 4'b0011, 4'b0000, 0); // p1 hungry, blocked
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0011, 4'b0000, 0); // age1=1
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0011, 4'b0000, 0); // age1=2
    add(0, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 0); // p0 done, age1=3
    add(0, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0110, 4'b0000, 0); // p1 granted
    add(0, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0); // p1 done
    add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0); // rr_ptr back to 0
    add(0, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0); // p0,p2 hungry
    add(0, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0011, 4'b0000, 0); // p0 first
    add(0, 4'b0000, 4'b0000, 4'b0100, 4'b0101, 4'b1111, 4'b0000, 0); // then p2
    add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0); // reset mid-meal
    add(0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0); // p0 hungry
    add(0, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0011, 4'b0000, 0); // p0 granted
    add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0); // reset
    add(0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0); // p1 hungry
    add(0, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0110, 4'b0000, 0); // p1 granted, rr=2
    add(0, 4'b1000, 4'b0000, 4'b0000, 4'b0010, 4'b0110, 4'b0000, 0); // p3 hungry
    add(0, 4'b0000, 4'b0000, 4'b1000, 4'b1010, 4'b1111, 4'b0000, 0); // p3 granted, rr=0
    add(0, 4'b0100, 4'b0000, 4'b0000, 4'b1010, 4'b1111, 4'b0000, 0); // p2 hungry, blocked
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b1010, 4'b1111, 4'b0000, 0); // age2=1
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b1010, 4'b1111, 4'b0000, 0); // age2=2
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b1010, 4'b1111, 4'b0100, 0); // age2=3 starving
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b1010, 4'b1111, 4'b0100, 0); // saturated
    add(0, 4'b0010, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 0); // done+hungry p1, no err
    add(0, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b1100, 4'b0000, 0); // old p2 beats fresh p1
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1100, 4'b0000, 0); // p1 age=2

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i]);
    end

    // Stray done to a thinking philosopher: sticky error, nothing else moves.
    v.rst = 0; v.h = 4'b0000; v.d = 4'b1000;
    v.may = 4'b0000; v.eat = 4'b0100; v.fb = 4'b1100; v.st = 4'b0010; v.err = 1;
    step(v);
    v.d = 4'b0000;
    step(v);
    v.d = 4'b1000; v.err = 1;
    step(v);
    // Only reset clears the error.
    v.rst = 1; v.d = 4'b0000;
    v.eat = 4'b0000; v.fb = 4'b0000; v.st = 4'b0000; v.err = 0;
    step(v);
    v.rst = 0;
    step(v);

    // Grant latency: request pulse, then bounded wait for the grant pulse.
    @(negedge clk);
    hungry = 4'b0001;
    @(posedge clk);
    #1;
    hungry = '0;
    lat = -1;
    for (int c = 0; c < 8; c++) begin
      if (may_eat == 4'b0001) begin
        lat = c;
        break;
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (lat != 1) begin
      n_fail++;
      $display("FAIL grant_latency: got %0d cycles want 1 (-1 = timed out)", lat);
    end
    $display("latency check: grant after %0d cycle(s)", lat);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
